// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone DDR2 port arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Nearest requester after last_idx wins; last_idx itself has lowest priority.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  last_idx,
                                           input int          n);
        logic [3:0] pick;
        int         idx;
        pick = last_idx;
        for (int i = 16; i >= 1; i--) begin
            if (i <= n) begin
                idx = (int'(last_idx) + i) % n;
                if (req[idx[3:0]]) pick = idx[3:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// Round-robin pointer with one-hot and binary grant registers.
module wb_rr_grant
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   load,
    input  logic                   drop,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx
);

    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] pick;

    assign pick = IDX_W'(rr_pick(16'(req), 4'(last_idx), NUM_MASTERS));

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_MASTERS - 1);
        end else if (load) begin
            grant     <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
            grant_idx <= pick;
            last_idx  <= pick;
        end else if (drop) begin
            grant     <= '0;
        end
    end

endmodule

// File: rtl/wb_ddr2_port_arbiter.sv
// N-to-1 Wishbone B3 arbiter for one DDR2 controller port; grant is held for a whole cyc.
// Optional ack watchdog enabled by defining ARB_WATCHDOG_EN.
module wb_ddr2_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int SW          = DW / 8
`ifdef ARB_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*SW-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    output logic [DW-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [SW-1:0]             wbs_sel_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic                      wbs_we_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    output logic [NUM_MASTERS-1:0]    grant_o
`ifdef ARB_WATCHDOG_EN
    ,
    output logic                      wdog_fired_o
`endif
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
        $error("wb_ddr2_port_arbiter: NUM_MASTERS must be in 2..16");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] grant_idx;
    logic             load;
    logic             drop;
    logic             kill;
    logic             timeout;

    assign load = (state == IDLE) && (|wbm_cyc_i);
    assign drop = (state == GRANT) && !wbm_cyc_i[grant_idx];

    wb_rr_grant #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_grant (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .req      (wbm_cyc_i),
        .load     (load),
        .drop     (drop),
        .grant    (grant_o),
        .grant_idx(grant_idx)
    );

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (load) state <= GRANT;
                GRANT:   if (drop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates cyc/stb combinationally so the slave sees them drop immediately.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        if (state == GRANT && !kill) begin
            wbs_adr_o = wbm_adr_i[int'(grant_idx)*AW +: AW];
            wbs_dat_o = wbm_dat_i[int'(grant_idx)*DW +: DW];
            wbs_sel_o = wbm_sel_i[int'(grant_idx)*SW +: SW];
            wbs_cti_o = wbm_cti_i[int'(grant_idx)*3 +: 3];
            wbs_bte_o = wbm_bte_i[int'(grant_idx)*2 +: 2];
            wbs_cyc_o = wbm_cyc_i[grant_idx] & ~wb_rst;
            wbs_stb_o = wbm_stb_i[grant_idx] & wbm_cyc_i[grant_idx] & ~wb_rst;
            wbs_we_o  = wbm_we_i[grant_idx];
        end
    end

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = grant_o & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = grant_o & {NUM_MASTERS{wbs_err_i | timeout}};
    assign wbm_rty_o = '0;

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES);

    logic [CW-1:0] wdog_cnt;
    logic          stb_wait;

    assign stb_wait = wbs_stb_o && !wbs_ack_i;
    assign timeout  = stb_wait && (wdog_cnt == CW'(WDOG_CYCLES - 1));

    // kill holds the slave side idle after a timeout until the master lets go.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wdog_cnt     <= '0;
            kill         <= 1'b0;
            wdog_fired_o <= 1'b0;
        end else if (state != GRANT || drop) begin
            wdog_cnt <= '0;
            kill     <= 1'b0;
        end else if (timeout) begin
            wdog_cnt     <= '0;
            kill         <= 1'b1;
            wdog_fired_o <= 1'b1;
        end else if (wbs_ack_i) begin
            wdog_cnt <= '0;
        end else if (stb_wait) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    assign kill    = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ddr2_port_arbiter.sv
// Directed self-checking bench for wb_ddr2_port_arbiter (4 masters, 32-bit bus).
module tb_wb_ddr2_port_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic [N*AW-1:0] wbm_adr_i;
    logic [N*DW-1:0] wbm_dat_i;
    logic [N*SW-1:0] wbm_sel_i;
    logic [N*3-1:0]  wbm_cti_i;
    logic [N*2-1:0]  wbm_bte_i;
    logic [N-1:0]    wbm_cyc_i, wbm_stb_i, wbm_we_i;
    logic [DW-1:0]   wbm_dat_o;
    logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [SW-1:0]   wbs_sel_o;
    logic [2:0]      wbs_cti_o;
    logic [1:0]      wbs_bte_o;
    logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i, wbs_err_i;
    logic [N-1:0]    grant_o;
`ifdef ARB_WATCHDOG_EN
    logic            wdog_fired_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 wb_clk = ~wb_clk;

    wb_ddr2_port_arbiter #(
        .NUM_MASTERS(N),
        .DW(DW),
        .AW(AW),
        .SW(SW)
`ifdef ARB_WATCHDOG_EN
        , .WDOG_CYCLES(16)
`endif
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .grant_o(grant_o)
`ifdef ARB_WATCHDOG_EN
        , .wdog_fired_o(wdog_fired_o)
`endif
    );

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        wb_rst = 1'b1;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
        wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
        wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
        tick(); tick();
        wb_rst = 1'b0;
        #1;
        check("rst_grant", 64'(grant_o), 64'h0);
        check("rst_cyc", 64'(wbs_cyc_o), 64'h0);
        check("rst_adr", 64'(wbs_adr_o), 64'h0);
        check("rst_ack", 64'(wbm_ack_o), 64'h0);
`ifdef ARB_WATCHDOG_EN
        check("rst_wdog", 64'(wdog_fired_o), 64'h0);
`endif

        // Two requesters; m1 first, then m2 after one idle cycle.
        wbm_adr_i[1*AW +: AW] = 32'h11;
        wbm_adr_i[2*AW +: AW] = 32'h22;
        wbm_cyc_i = 4'b0110; wbm_stb_i = 4'b0110;
        #1;
        check("t1_pre_grant", 64'(grant_o), 64'h0);
        tick();
        check("t1_grant_m1", 64'(grant_o), 64'h2);
        check("t1_cyc_m1", 64'(wbs_cyc_o), 64'h1);
        check("t1_adr_m1", 64'(wbs_adr_o), 64'h11);
        wbm_cyc_i = 4'b0100; wbm_stb_i = 4'b0100;
        tick();
        check("t1_idle_grant", 64'(grant_o), 64'h0);
        check("t1_idle_cyc", 64'(wbs_cyc_o), 64'h0);
        tick();
        check("t1_grant_m2", 64'(grant_o), 64'h4);
        check("t1_adr_m2", 64'(wbs_adr_o), 64'h22);
        wbm_cyc_i = '0; wbm_stb_i = '0;
        tick(); tick();

        // Fresh reset, then all four masters hammer with classic single reads.
        wb_rst = 1'b1; tick(); wb_rst = 1'b0;
        wbm_cyc_i = 4'b1111; wbm_stb_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("t2_grant", 64'(grant_o), 64'(4'b0001 << (g % 4)));
            check("t2_cyc", 64'(wbs_cyc_o), 64'h1);
            wbs_ack_i = 1'b1;
            #1;
            check("t2_ack", 64'(wbm_ack_o), 64'(4'b0001 << (g % 4)));
            tick();
            wbs_ack_i = 1'b0;
            wbm_cyc_i[g % 4] = 1'b0;
            tick();
            check("t2_gap_cyc", 64'(wbs_cyc_o), 64'h0);
            check("t2_gap_grant", 64'(grant_o), 64'h0);
            wbm_cyc_i[g % 4] = 1'b1;
        end
        wbm_cyc_i = '0; wbm_stb_i = '0;
        tick();

        // m2 8-beat INCR burst with one stb gap while m0 waits.
        wbm_cyc_i = 4'b0101; wbm_stb_i = 4'b0101;
        wbm_adr_i[2*AW +: AW] = 32'h100;
        wbm_cti_i[2*3 +: 3] = CTI_INCR;
        tick();
        check("t3_grant_m2", 64'(grant_o), 64'h4);
        for (int b = 0; b < 8; b++) begin
            wbm_adr_i[2*AW +: AW] = 32'h100 + 32'(4 * b);
            wbm_cti_i[2*3 +: 3] = (b == 7) ? CTI_EOB : CTI_INCR;
            wbs_ack_i = 1'b1;
            #1;
            check("t3_adr", 64'(wbs_adr_o), 64'(32'h100 + 32'(4 * b)));
            check("t3_ack_m2_only", 64'(wbm_ack_o), 64'h4);
            check("t3_cti", 64'(wbs_cti_o), (b == 7) ? 64'h7 : 64'h2);
            tick();
            if (b == 3) begin
                wbs_ack_i = 1'b0;
                wbm_stb_i[2] = 1'b0;
                tick();
                check("t3_gap_grant", 64'(grant_o), 64'h4);
                check("t3_gap_stb", 64'(wbs_stb_o), 64'h0);
                check("t3_gap_cyc", 64'(wbs_cyc_o), 64'h1);
                wbm_stb_i[2] = 1'b1;
            end
        end
        wbs_ack_i = 1'b0;
        wbm_cyc_i[2] = 1'b0; wbm_stb_i[2] = 1'b0;
        wbm_cti_i = '0;
        tick();
        check("t3_release", 64'(grant_o), 64'h0);
        tick();
        check("t3_grant_m0", 64'(grant_o), 64'h1);
        wbm_cyc_i = '0; wbm_stb_i = '0;
        tick(); tick();

        // m1 write; data mux, sel, and response routing.
        wbm_dat_i[0*DW +: DW] = 32'h01010101;
        wbm_dat_i[1*DW +: DW] = 32'hDEADBEEF;
        wbm_dat_i[2*DW +: DW] = 32'h02020202;
        wbm_sel_i[1*SW +: SW] = 4'hF;
        wbm_we_i = 4'b0010;
        wbm_cyc_i = 4'b0010; wbm_stb_i = 4'b0010;
        wbs_dat_i = 32'hCAFEF00D;
        tick();
        check("t4_grant_m1", 64'(grant_o), 64'h2);
        check("t4_dat", 64'(wbs_dat_o), 64'hDEADBEEF);
        check("t4_we", 64'(wbs_we_o), 64'h1);
        check("t4_sel", 64'(wbs_sel_o), 64'hF);
        check("t4_rdata", 64'(wbm_dat_o), 64'hCAFEF00D);
        wbs_ack_i = 1'b1;
        #1;
        check("t4_ack_m1", 64'(wbm_ack_o), 64'h2);
        wbs_ack_i = 1'b0; wbs_err_i = 1'b1;
        #1;
        check("t4_err_m1", 64'(wbm_err_o), 64'h2);
        check("t4_rty", 64'(wbm_rty_o), 64'h0);
        wbs_err_i = 1'b0;
        wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
        tick(); tick();

        // Reset in the middle of an m3 burst.
        wbm_cyc_i = 4'b1000; wbm_stb_i = 4'b1000;
        wbm_cti_i[3*3 +: 3] = CTI_INCR;
        tick();
        check("t5_grant_m3", 64'(grant_o), 64'h8);
        wbs_ack_i = 1'b1;
        tick();
        wb_rst = 1'b1;
        #1;
        check("t5_rst_cyc", 64'(wbs_cyc_o), 64'h0);
        check("t5_rst_stb", 64'(wbs_stb_o), 64'h0);
        tick();
        wbs_ack_i = 1'b0;
        check("t5_rst_grant", 64'(grant_o), 64'h0);
        wb_rst = 1'b0;
        wbm_cti_i = '0;
        wbm_cyc_i = 4'b1111; wbm_stb_i = 4'b1111;
        tick();
        check("t5_first_m0", 64'(grant_o), 64'h1);
        wbm_cyc_i = '0; wbm_stb_i = '0;
        tick(); tick();

`ifdef ARB_WATCHDOG_EN
        // Hung slave: m0 times out on stb cycle 16, then m1 gets the port.
        wb_rst = 1'b1; tick(); wb_rst = 1'b0;
        wbm_cyc_i = 4'b0001; wbm_stb_i = 4'b0001;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 2) wbm_cyc_i[1] = 1'b1;
            check("wd_err", 64'(wbm_err_o), (c == 16) ? 64'h1 : 64'h0);
        end
        check("wd_hold_m0", 64'(grant_o), 64'h1);
        tick();
        check("wd_err_cleared", 64'(wbm_err_o), 64'h0);
        check("wd_cyc_low", 64'(wbs_cyc_o), 64'h0);
        check("wd_fired", 64'(wdog_fired_o), 64'h1);
        wbm_cyc_i[0] = 1'b0; wbm_stb_i[0] = 1'b0;
        wbm_stb_i[1] = 1'b1;
        tick();
        check("wd_release", 64'(grant_o), 64'h0);
        tick();
        check("wd_grant_m1", 64'(grant_o), 64'h2);
        check("wd_sticky", 64'(wdog_fired_o), 64'h1);
        wbm_cyc_i = '0; wbm_stb_i = '0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_ddr2_port_arbiter.md
Name: wb_ddr2_port_arbiter

Overview:
Parametrised N-to-1 Wishbone B3 arbiter for one DDR2 controller slave port. It lets more masters share a port than the controller has ports. Round-robin grant is locked for the whole cyc_i cycle, so bursts are never split. Sits between bus masters and one wbN_* port of the DDR2 controller wrapper.

Parameters:
NUM_MASTERS, 4, number of master ports (2..16)
DW, 32, data width
AW, 32, address width
SW, DW/8, byte-select width
IDX_W, $clog2(NUM_MASTERS), grant index width (derived, not overridable)
WDOG_CYCLES, 1024, ack timeout in cycles (only with the optional feature)

Ports:
wb_clk  in  1  clock
wb_rst  in  1  synchronous active-high reset
wbm_adr_i  in  NUM_MASTERS*AW  packed master addresses, master k at [k*AW +: AW]
wbm_dat_i  in  NUM_MASTERS*DW  packed write data
wbm_sel_i  in  NUM_MASTERS*SW  packed byte selects
wbm_cti_i  in  NUM_MASTERS*3  packed cycle-type ids
wbm_bte_i  in  NUM_MASTERS*2  packed burst-type ext
wbm_cyc_i / wbm_stb_i / wbm_we_i  in  NUM_MASTERS each  per-master strobes
wbm_dat_o  out  DW  slave read data, broadcast to all masters
wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS each  per-master responses
wbs_adr_o  out  AW  to slave
wbs_dat_o  out  DW  to slave
wbs_sel_o  out  SW  to slave
wbs_cti_o  out  3  to slave
wbs_bte_o  out  2  to slave
wbs_cyc_o / wbs_stb_o / wbs_we_o  out  1 each  to slave
wbs_dat_i / wbs_ack_i / wbs_err_i  in  DW/1/1  from slave
grant_o  out  NUM_MASTERS  one-hot current grant (debug/perf)

Behaviour:
- One clock domain, wb_clk. Reset is synchronous and active-high on wb_rst.
- Reset values:
  - state=IDLE, grant=0, last_idx=NUM_MASTERS-1, so master 0 wins first.
  - All wbs_* outputs 0; all wbm_ack/err/rty 0.
- FSM IDLE -> GRANT -> IDLE:
  - IDLE: the slave sees cyc=stb=0 and every other wbs_* output = 0.
  - IDLE, any wbm_cyc_i set: pick the first requester scanning last_idx+1, last_idx+2, ... modulo NUM_MASTERS. Register it into grant, update last_idx, go to GRANT.
  - Arbitration latency: exactly 1 cycle, from cyc seen in IDLE to wbs_cyc_o high.
  - GRANT: wbs_* is a combinational mux of the granted master's inputs. wbm_ack_o[k] = wbs_ack_i & grant[k]; likewise err. Ungranted masters see ack/err = 0.
  - GRANT -> IDLE: when the granted master's cyc_i is low at a clock edge.
  - There is one mandatory IDLE cycle between grants (wbs_cyc_o low for at least 1 cycle), even if other masters are waiting.
- Grant stays locked while granted cyc_i is high, including incrementing or wrap bursts (cti 010) and stb gaps. Other requests are ignored until release.
- Fairness: with M masters continuously requesting, each master is granted once per M grants.
- Simultaneous events: a release and a new request in the same cycle are resolved in the following IDLE cycle. A master that drops cyc the same cycle as its final ack is released normally.
- wbm_rty_o is always 0. Slave errors are forwarded only to the granted master.
- Reset mid-transaction: the next edge forces IDLE. wbs_cyc_o/stb_o drop in the same cycle the reset is sampled. last_idx goes back to NUM_MASTERS-1.
- NUM_MASTERS=1 is illegal: elaboration-time error.

Optional Feature:
ARB_WATCHDOG_EN
- Defined:
  - A counter runs in GRANT while wbs_stb_o=1 and wbs_ack_i=0; it clears on ack or on leaving GRANT.
  - When it reaches WDOG_CYCLES-1: assert wbm_err_o[granted] for exactly 1 cycle, drive wbs_cyc_o/stb_o low from the next cycle, and go IDLE once the master drops cyc.
  - A sticky wdog_fired_o output port (1 bit) is added; it clears only on wb_rst.
- Undefined: no counter, no extra port, no timeout. A hung slave holds the grant indefinitely.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, GRANT}
  - Wishbone CTI/BTE localparams (CLASSIC=000, INCR=010, EOB=111)
  - function rr_pick(req, last_idx) returning the next index
- One sub-module, wb_rr_grant: round-robin pointer plus one-hot/index grant register. The top holds the FSM, muxes, response gating and watchdog.

Test Plan:
- Reset, then wbm_cyc_i=4'b0110 held -> grant_o=4'b0010 one cycle later. After m1 drops cyc: one idle cycle, then grant_o=4'b0100.
- All 4 masters request continuously with single classic reads -> grant order 0,1,2,3,0. Each slave cycle is separated by exactly one wbs_cyc_o=0 cycle.
- m2 runs an 8-beat INCR burst (cti 010...111) at adr 0x100 while m0 requests -> all 8 acks reach m2 only; m0 is granted only after m2 drops cyc.
- m1 write, dat 0xDEADBEEF, sel 4'hF -> wbs_dat_o=0xDEADBEEF, wbs_we_o=1. wbs_ack_i is routed to wbm_ack_o[1] only; the others stay 0.
- wb_rst asserted mid-burst of m3 -> wbs_cyc_o=0 in the same cycle. After release, with all masters requesting, m0 is granted first.
- With ARB_WATCHDOG_EN and WDOG_CYCLES=16, slave never acks m0 -> wbm_err_o[0] pulses on stb cycle 16 and wdog_fired_o=1. m1 is then granted after m0 drops cyc.
